// File: rtl/edf_sched_ic_pkg.sv
// -----------------------------------------------------------------------------
// edf_sched_ic_pkg
// Shared definitions for the earliest-deadline-first interrupt controller:
//   - cfg register offsets (relative to the controller base address)
//   - scanner FSM state encoding
//   - saturating deadline adder used by the per-source gateways
// -----------------------------------------------------------------------------
package edf_sched_ic_pkg;

    localparam logic [31:0] REL_DL_OFS  = 32'h0000_0000;
    localparam logic [31:0] ENABLE_OFS  = 32'h0000_0100;
    localparam logic [31:0] PENDING_OFS = 32'h0000_0104;
    localparam logic [31:0] MISS_OFS    = 32'h0000_0108;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } edf_state_e;

    // Adds two unsigned operands that each fit in 'width' bits and clamps the
    // result to the largest 'width'-bit value. The sum is formed one bit wider
    // than 64 so that a carry out of a full 64-bit timestamp is still visible.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/edf_sched_ic_gateway.sv
// -----------------------------------------------------------------------------
// edf_gateway
// Per-source request gateway. Detects a rising edge on the source's IRQ line,
// latches it as pending and stamps the absolute deadline mtime + rel_dl
// (saturating at all-ones). A new edge always wins over a same-cycle clear,
// and re-stamps the deadline if the source was already pending.
//
// Optional feature: macro EDF_SCHED_IC_MISS_EN adds a sticky deadline-miss
// flag (set while pending and mtime >= abs_dl, cleared by miss_clr_i).
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   irq_i          level IRQ input of this source
//   mtime_i        current time
//   rel_dl_i       programmed relative deadline
//   clr_i          pending clear (W1C or claim)
//   miss_clr_i     miss flag clear          (EDF_SCHED_IC_MISS_EN only)
//   miss_o         sticky miss flag          (EDF_SCHED_IC_MISS_EN only)
//   pending_o      pending flag
//   abs_dl_o       stamped absolute deadline
// -----------------------------------------------------------------------------
module edf_gateway
    import edf_sched_ic_pkg::*;
#(
    parameter int TsWidth  = 64,
    parameter int RelWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                irq_i,
    input  logic [TsWidth-1:0]  mtime_i,
    input  logic [RelWidth-1:0] rel_dl_i,
    input  logic                clr_i,
`ifdef EDF_SCHED_IC_MISS_EN
    input  logic                miss_clr_i,
    output logic                miss_o,
`endif
    output logic                pending_o,
    output logic [TsWidth-1:0]  abs_dl_o
);

    logic               irq_q_reg;
    logic               pending_reg;
    logic               pending_next;
    logic [TsWidth-1:0] abs_dl_reg;
    logic [TsWidth-1:0] abs_dl_next;
    logic [TsWidth-1:0] stamp;
    logic               edge_set;

    assign edge_set = irq_i & ~irq_q_reg;
    assign stamp    = TsWidth'(sat_add(64'(mtime_i), 64'(rel_dl_i), TsWidth));

    always_comb begin
        pending_next = pending_reg;
        abs_dl_next  = abs_dl_reg;
        if (edge_set) begin
            pending_next = 1'b1;
            abs_dl_next  = stamp;
        end else if (clr_i) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q_reg   <= 1'b0;
            pending_reg <= 1'b0;
            abs_dl_reg  <= '0;
        end else begin
            irq_q_reg   <= irq_i;
            pending_reg <= pending_next;
            abs_dl_reg  <= abs_dl_next;
        end
    end

    assign pending_o = pending_reg;
    assign abs_dl_o  = abs_dl_reg;

`ifdef EDF_SCHED_IC_MISS_EN
    logic miss_reg;
    logic miss_next;

    // A still-late pending source re-asserts the flag even in a clearing cycle.
    always_comb begin
        miss_next = miss_reg;
        if (miss_clr_i) begin
            miss_next = 1'b0;
        end
        if (pending_reg && (mtime_i >= abs_dl_reg)) begin
            miss_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_reg <= 1'b0;
        end else begin
            miss_reg <= miss_next;
        end
    end

    assign miss_o = miss_reg;
`endif

endmodule

// File: rtl/edf_sched_ic.sv
// -----------------------------------------------------------------------------
// edf_sched_ic
// Earliest-deadline-first interrupt controller. Each source gets a gateway
// that stamps an absolute deadline on its rising edge; a sequential scanner
// visits one source per cycle, keeps the earliest eligible deadline (ties to
// the lower index) and presents the winner through a valid/ready claim.
//
// Optional feature: macro EDF_SCHED_IC_MISS_EN enables deadline-miss flags,
// the MISS register contents and the dl_miss_o port.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   cfg_req_i        cfg access strobe
//   cfg_we_i         1 = write
//   cfg_addr_i       byte address
//   cfg_wdata_i      write data
//   cfg_rdata_o      registered read data (holds until the next read)
//   mtime_i          current time
//   irq_i            level IRQ inputs, rising edge = request
//   irq_id_o         presented winner
//   irq_valid_o      winner presented
//   irq_ready_i      core claims the winner
//   dl_miss_o        OR of miss flags (EDF_SCHED_IC_MISS_EN only)
// -----------------------------------------------------------------------------
module edf_sched_ic
    import edf_sched_ic_pkg::*;
#(
    parameter int          NrIrqs   = 8,
    parameter int          TsWidth  = 64,
    parameter int          RelWidth = 32,
    parameter logic [31:0] BaseAddr = 32'h0,
    localparam int         IdWidth  = $clog2(NrIrqs)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [31:0]        cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic [TsWidth-1:0] mtime_i,
    input  logic [NrIrqs-1:0]  irq_i,
    output logic [IdWidth-1:0] irq_id_o,
    output logic               irq_valid_o,
`ifdef EDF_SCHED_IC_MISS_EN
    output logic               dl_miss_o,
`endif
    input  logic               irq_ready_i
);

    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrIrqs - 1);

    // ---------------------------------------------------------------------
    // cfg decode
    // ---------------------------------------------------------------------
    logic [31:0]         addr_ofs;
    logic                cfg_wr;
    logic                cfg_rd;
    logic                rel_hit;
    logic [IdWidth-1:0]  rel_idx;

    assign addr_ofs = cfg_addr_i - BaseAddr;
    assign cfg_wr   = cfg_req_i & cfg_we_i;
    assign cfg_rd   = cfg_req_i & ~cfg_we_i;
    assign rel_hit  = (addr_ofs < 32'(4 * NrIrqs)) && (addr_ofs[1:0] == 2'b00);
    assign rel_idx  = addr_ofs[IdWidth+1:2];

    // ---------------------------------------------------------------------
    // REL_DL and ENABLE registers
    // ---------------------------------------------------------------------
    logic [RelWidth-1:0] rel_dl_reg [NrIrqs];
    logic [NrIrqs-1:0]   enable_reg;

    for (genvar gi = 0; gi < NrIrqs; gi++) begin : g_rel_dl
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rel_dl_reg[gi] <= '0;
            end else if (cfg_wr && rel_hit && (rel_idx == IdWidth'(gi))) begin
                rel_dl_reg[gi] <= cfg_wdata_i[RelWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_reg <= '0;
        end else if (cfg_wr && (addr_ofs == ENABLE_OFS)) begin
            enable_reg <= cfg_wdata_i[NrIrqs-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Gateways
    // ---------------------------------------------------------------------
    logic [NrIrqs-1:0]  pending;
    logic [TsWidth-1:0] abs_dl [NrIrqs];
    logic [NrIrqs-1:0]  w1c_pending;
    logic [NrIrqs-1:0]  claim_mask;
    logic [NrIrqs-1:0]  eligible;
    logic               claim;

    assign w1c_pending = (cfg_wr && (addr_ofs == PENDING_OFS)) ? cfg_wdata_i[NrIrqs-1:0] : '0;
    assign eligible    = pending & enable_reg;

`ifdef EDF_SCHED_IC_MISS_EN
    logic [NrIrqs-1:0] miss;
    logic [NrIrqs-1:0] w1c_miss;
    assign w1c_miss  = (cfg_wr && (addr_ofs == MISS_OFS)) ? cfg_wdata_i[NrIrqs-1:0] : '0;
    assign dl_miss_o = |miss;
`endif

    for (genvar gi = 0; gi < NrIrqs; gi++) begin : g_gw
        edf_gateway #(
            .TsWidth  (TsWidth),
            .RelWidth (RelWidth)
        ) u_gw (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .irq_i      (irq_i[gi]),
            .mtime_i    (mtime_i),
            .rel_dl_i   (rel_dl_reg[gi]),
            .clr_i      (w1c_pending[gi] | claim_mask[gi]),
`ifdef EDF_SCHED_IC_MISS_EN
            .miss_clr_i (w1c_miss[gi]),
            .miss_o     (miss[gi]),
`endif
            .pending_o  (pending[gi]),
            .abs_dl_o   (abs_dl[gi])
        );
    end

    // ---------------------------------------------------------------------
    // Scanner FSM
    // ---------------------------------------------------------------------
    edf_state_e         state_reg, state_next;
    logic [IdWidth-1:0] idx_reg, idx_next;
    logic               best_valid_reg, best_valid_next;
    logic [IdWidth-1:0] best_id_reg, best_id_next;
    logic [TsWidth-1:0] best_dl_reg, best_dl_next;
    logic [IdWidth-1:0] irq_id_reg, irq_id_next;
    logic               cand_better;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        best_valid_next = best_valid_reg;
        best_id_next    = best_id_reg;
        best_dl_next    = best_dl_reg;
        irq_id_next     = irq_id_reg;
        cand_better     = 1'b0;
        claim           = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    state_next      = SCAN;
                    idx_next        = '0;
                    best_valid_next = 1'b0;
                end
            end
            SCAN: begin
                // Strict less-than keeps the earlier (lower) index on ties.
                cand_better = eligible[idx_reg] &&
                              (!best_valid_reg || (abs_dl[idx_reg] < best_dl_reg));
                if (cand_better) begin
                    best_valid_next = 1'b1;
                    best_id_next    = idx_reg;
                    best_dl_next    = abs_dl[idx_reg];
                end
                if (idx_reg == LastIdx) begin
                    // The best may have been cleared or disabled mid-scan;
                    // only present it if it is still eligible now.
                    if (best_valid_next && eligible[best_id_next]) begin
                        state_next  = PRESENT;
                        irq_id_next = best_id_next;
                    end else if (|eligible) begin
                        idx_next        = '0;
                        best_valid_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            PRESENT: begin
                if (irq_ready_i) begin
                    claim      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            best_valid_reg <= 1'b0;
            best_id_reg    <= '0;
            best_dl_reg    <= '0;
            irq_id_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            best_valid_reg <= best_valid_next;
            best_id_reg    <= best_id_next;
            best_dl_reg    <= best_dl_next;
            irq_id_reg     <= irq_id_next;
        end
    end

    assign claim_mask  = claim ? (NrIrqs'(1) << irq_id_reg) : '0;
    assign irq_valid_o = (state_reg == PRESENT);
    assign irq_id_o    = irq_id_reg;

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    logic [31:0] rdata_reg, rdata_next;

    always_comb begin
        rdata_next = '0;
        if (rel_hit) begin
            rdata_next = 32'(rel_dl_reg[rel_idx]);
        end else if (addr_ofs == ENABLE_OFS) begin
            rdata_next = 32'(enable_reg);
        end else if (addr_ofs == PENDING_OFS) begin
            rdata_next = 32'(pending);
        end else if (addr_ofs == MISS_OFS) begin
`ifdef EDF_SCHED_IC_MISS_EN
            rdata_next = 32'(miss);
`else
            rdata_next = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_reg <= '0;
        end else if (cfg_rd) begin
            rdata_reg <= rdata_next;
        end
    end

    assign cfg_rdata_o = rdata_reg;

endmodule

// File: doc/edf_sched_ic.md
# edf_sched_ic

Earliest-deadline-first interrupt controller, next generation of the EDF arbiter. Each source has a programmable relative deadline. On a rising edge, the source's absolute deadline is stamped as `mtime + relative deadline`. A sequential scanner picks the earliest-deadline pending, enabled source and presents it to the core through a valid/ready claim handshake. It sits between peripheral IRQ lines and the core's interrupt interface, configured over the 32-bit cfg bus.

## Interface
- `NrIrqs`, 8: number of sources, 2..32.
- `TsWidth`, 64: timestamp and absolute deadline width, 32..64.
- `RelWidth`, 32: relative deadline register width, ≤ 32.
- `BaseAddr`, 0: cfg base address.
- `IdWidth`, localparam `$clog2(NrIrqs)`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cfg_req_i`  in  1  cfg access strobe.
- `cfg_we_i`  in  1  1 = write.
- `cfg_addr_i`  in  32  byte address.
- `cfg_wdata_i`  in  32  write data.
- `cfg_rdata_o`  out  32  read data, registered.
- `mtime_i`  in  TsWidth  current time.
- `irq_i`  in  NrIrqs  level inputs; rising edge = request.
- `irq_id_o`  out  IdWidth  winning source.
- `irq_valid_o`  out  1  winner presented.
- `irq_ready_i`  in  1  core claims winner.
- `dl_miss_o`  out  1  OR of sticky miss flags; only when `EDF_SCHED_IC_MISS_EN` is defined.

## Operation
- Register map, offsets from `BaseAddr`:
  - `0x000 + 4*i`: `REL_DL[i]`, R/W, width `RelWidth`, zero-extended on read.
  - `0x100`: `ENABLE`, R/W.
  - `0x104`: `PENDING`, R, write-1-to-clear.
  - `0x108`: `MISS`, R/W1C; reads 0 without the macro.
  - Unmapped addresses read 0; writes to them are ignored.
- Edge detect: `irq_q` holds the last sample of `irq_i`. Pending is set when `irq_i[i] & ~irq_q[i]`, whether or not the source is enabled.
- Deadline stamp: on set, `abs_dl[i] = mtime_i + REL_DL[i]`, computed in `TsWidth+1` bits.
  - On overflow, saturate to all-ones.
  - A re-edge while already pending restamps the deadline.
- Eligible: `pending[i] & ENABLE[i]`.
- FSM states: `IDLE`, `SCAN`, `PRESENT`.
  - `IDLE`: if any source is eligible, go to `SCAN`; reset `idx` to 0 and the best-so-far to invalid.
  - `SCAN`: one index per cycle.
    - An eligible candidate replaces the best when the best is invalid or when `abs_dl` is strictly less.
    - Ties go to the lower index.
    - After `idx == NrIrqs-1`: if the best is still eligible, go to `PRESENT`. Otherwise, restart `SCAN` if anything is eligible, else go to `IDLE`.
  - `PRESENT`: `irq_valid_o = 1`. `irq_id_o` stays stable until `irq_ready_i`. Disabling or W1C-clearing the winner does not retract valid.
    - On ready, clear `pending[id]` and go to `IDLE`.
- Simultaneous events:
  - Same-cycle claim and new edge on the same source: the set wins and the deadline is restamped.
  - Same-cycle W1C and edge: the set wins.
  - A new earlier deadline arriving during `PRESENT` does not preempt; it is considered on the next scan.

## Timing
- Reset values: `irq_valid_o = 0`, `irq_id_o = 0`, `cfg_rdata_o = 0`, `dl_miss_o = 0`. All registers zero, FSM in `IDLE`.
- Cfg writes take effect at the next edge.
- Reads: `cfg_rdata_o` is valid in the cycle after `cfg_req_i & ~cfg_we_i` and holds until the next read.
- Latency:
  - Edge sampled at edge k → pending visible in cycle k+1.
  - If the FSM is idle, `irq_valid_o` rises at cycle k+1+1+NrIrqs, i.e. `IDLE` 1 cycle + `SCAN` NrIrqs cycles.
  - After ready, the FSM returns to `IDLE` next cycle; the next valid follows NrIrqs+1 cycles later if work is pending.
- Asserting reset mid-scan or mid-present: outputs and state return to reset values at the next edge. A claim in the same cycle as reset is dropped.

## Configuration
- Macro `EDF_SCHED_IC_MISS_EN`, defined:
  - Each cycle, set `miss[i]` when `pending[i]` is set and `mtime_i >= abs_dl[i]`.
  - `miss[i]` is sticky until W1C at `0x108`.
  - `dl_miss_o = |miss`.
- Not defined: no miss logic, `MISS` reads 0, no `dl_miss_o` port.

## Structure
- Package `edf_sched_ic_pkg`:
  - Register offset constants (`REL_DL_OFS`, `ENABLE_OFS`, `PENDING_OFS`, `MISS_OFS`).
  - FSM state enum `edf_state_e`.
  - Saturating-add function.
- Sub-module `edf_gateway`, one per source. It holds the edge detect, pending flag, deadline stamp, W1C/claim clear and the optional miss flag. Outputs `pending_o`, `abs_dl_o`, `miss_o`.
- The top level holds the cfg decode, `REL_DL`/`ENABLE` registers, scanner FSM and read mux.

## Test plan
- Reset, then NrIrqs=4. `REL_DL = {100, 50, 200, 50}`, `ENABLE = 0xF`, `mtime = 1000`, edges on all sources in the same cycle → id 1 presented at cycle k+6 (4 scan cycles + 2); tie with id 3 is broken low.
- Hold `irq_ready_i = 0` for 10 cycles, then raise `irq_valid_o`-time edge on id 0 with `REL_DL[0] = 1` → id stays 1 with no preemption. After ready, `PENDING[1]` clears and the next winner is id 0.
- `ENABLE = 0x2`, edges on ids 0 and 1 → only id 1 is presented. After the claim, `PENDING` reads `0x1` and valid stays 0.
- `REL_DL[2] = 0xFFFFFFFF`, `mtime = 2^64-10`, edge on id 2 → `abs_dl` saturates to all-ones; id 2 loses to any unsaturated deadline.
- W1C of the winner during `SCAN` → rescan; that id is not presented.
- With `EDF_SCHED_IC_MISS_EN`: `REL_DL[0] = 5`, edge, mtime advances 5 without claim → `dl_miss_o = 1`. W1C `0x108 = 0x1` → 0.
